// File: rtl/hilo_unit_pkg.sv
// hilo_unit_pkg: shared constants for the HI/LO register block.
//   - HILO_SEL_LO / HILO_SEL_HI : encoding of mt_sel / mf_sel
//   - HILO_DATA_W               : default HI/LO and data-port width
//   - HILO_CNT_W                : default in-flight multiply counter width
//   - HILO_MUL_LAT              : MUL unit latency (issue to completion strobe)
package hilo_unit_pkg;

  localparam int HILO_DATA_W  = 32;
  localparam int HILO_CNT_W   = 3;
  localparam int HILO_MUL_LAT = 6;

  localparam logic HILO_SEL_LO = 1'b0;
  localparam logic HILO_SEL_HI = 1'b1;

endpackage

// File: rtl/hilo_unit_scoreboard.sv
// hilo_scoreboard: saturating up/down count of multiplies in flight.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   flush             : drops all in-flight multiplies (count -> 0)
//   mul_issue         : a multiply enters MUL this cycle
//   mul_done          : MUL completion strobe
//   busy              : registered (count != 0)
//   seq_err           : sticky overflow/underflow flag, cleared by reset only
module hilo_scoreboard #(
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic mul_issue,
  input  logic mul_done,
  output logic busy,
  output logic seq_err
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_err;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_err_nxt;

  // Next count and error flag; flush wins and never raises an error.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_err_nxt = r_err;
    if (flush) begin
      w_cnt_nxt = CNT_ZERO;
    end else begin
      case ({mul_issue, mul_done})
        2'b10: begin
          if (r_cnt == CNT_MAX) begin
            w_err_nxt = 1'b1;            // saturate
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        2'b01: begin
          if (r_cnt == CNT_ZERO) begin
            w_err_nxt = 1'b1;            // completion with nothing in flight
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
        2'b11: begin
          // Count is unchanged; a completion with nothing in flight is
          // still an unmatched strobe.
          if (r_cnt == CNT_ZERO) begin
            w_err_nxt = 1'b1;
          end else begin
            w_err_nxt = r_err;
          end
        end
        default: begin
          w_cnt_nxt = r_cnt;
        end
      endcase
    end
  end

  // Counter, registered busy and sticky error state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= CNT_ZERO;
      r_busy <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_busy <= (w_cnt_nxt != CNT_ZERO);
      r_err  <= w_err_nxt;
    end
  end

  assign busy    = r_busy;
  assign seq_err = r_err;

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: architectural HI/LO registers at the consumer end of MUL.
// Captures mul_hi/mul_lo on mul_done, accepts MTHI/MTLO while no multiply
// is in flight, and returns MFHI/MFLO through a one-entry output register
// handshaked with writeback (mf_valid / wb_allin).
// Ports:
//   clk, reset, flush              : clock, sync active-high reset, pipeline flush
//   mul_issue, mul_done            : multiply issue / completion strobes
//   mul_hi, mul_lo                 : MUL results, valid with mul_done
//   mt_en, mt_sel, mt_data, mt_ready : move-to request and acceptance
//   mf_req, mf_sel, mf_ready       : move-from request and acceptance
//   mf_valid, mf_data, wb_allin    : output register and WB handshake
//   busy, hi_q, lo_q, seq_err      : status and architectural state
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int DATA_W = HILO_DATA_W,
  parameter int CNT_W  = HILO_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              mul_issue,
  input  logic              mul_done,
  input  logic [DATA_W-1:0] mul_hi,
  input  logic [DATA_W-1:0] mul_lo,
  input  logic              mt_en,
  input  logic              mt_sel,
  input  logic [DATA_W-1:0] mt_data,
  output logic              mt_ready,
  input  logic              mf_req,
  input  logic              mf_sel,
  output logic              mf_ready,
  output logic              mf_valid,
  output logic [DATA_W-1:0] mf_data,
  input  logic              wb_allin,
  output logic              busy,
  output logic [DATA_W-1:0] hi_q,
  output logic [DATA_W-1:0] lo_q,
  output logic              seq_err
);

  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  logic              w_busy;
  logic              w_sb_err;
  logic              w_mt_ready;
  logic              w_mf_ready;
  logic              w_mt_acc;
  logic              w_mf_acc;

  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic              r_mf_valid;
  logic [DATA_W-1:0] r_mf_data;

  logic [DATA_W-1:0] w_hi_nxt;
  logic [DATA_W-1:0] w_lo_nxt;
  logic              w_mf_valid_nxt;
  logic [DATA_W-1:0] w_mf_data_nxt;

  hilo_scoreboard #(
    .CNT_W (CNT_W)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .mul_issue (mul_issue),
    .mul_done  (mul_done),
    .busy      (w_busy),
    .seq_err   (w_sb_err)
  );

  // Handshake readiness depends only on state and wb_allin.
  always_comb begin
    w_mt_ready = ~w_busy;
    w_mf_ready = ~w_busy & (~r_mf_valid | wb_allin);
    w_mt_acc   = mt_en  & w_mt_ready & ~flush;
    w_mf_acc   = mf_req & w_mf_ready & ~flush;
  end

  // HI/LO next state: committed state survives flush; a completion
  // coinciding with flush belongs to a squashed multiply and is dropped.
  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (flush) begin
      w_hi_nxt = r_hi;
    end else if (mul_done) begin
      w_hi_nxt = mul_hi;
      w_lo_nxt = mul_lo;
    end else if (w_mt_acc) begin
      case (mt_sel)
        HILO_SEL_HI: w_hi_nxt = mt_data;
        default:     w_lo_nxt = mt_data;
      endcase
    end else begin
      w_hi_nxt = r_hi;
    end
  end

  // Output register: reads use pre-edge HI/LO, so a same-cycle MT to the
  // same register is not forwarded.
  always_comb begin
    w_mf_valid_nxt = r_mf_valid;
    w_mf_data_nxt  = r_mf_data;
    if (flush) begin
      w_mf_valid_nxt = 1'b0;
    end else if (w_mf_acc) begin
      w_mf_valid_nxt = 1'b1;
      case (mf_sel)
        HILO_SEL_HI: w_mf_data_nxt = r_hi;
        default:     w_mf_data_nxt = r_lo;
      endcase
    end else if (wb_allin) begin
      w_mf_valid_nxt = 1'b0;
    end else begin
      w_mf_valid_nxt = r_mf_valid;
    end
  end

  // Architectural and output register state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi       <= DATA_ZERO;
      r_lo       <= DATA_ZERO;
      r_mf_valid <= 1'b0;
      r_mf_data  <= DATA_ZERO;
    end else begin
      r_hi       <= w_hi_nxt;
      r_lo       <= w_lo_nxt;
      r_mf_valid <= w_mf_valid_nxt;
      r_mf_data  <= w_mf_data_nxt;
    end
  end

  assign mt_ready = w_mt_ready;
  assign mf_ready = w_mf_ready;
  assign mf_valid = r_mf_valid;
  assign mf_data  = r_mf_data;
  assign busy     = w_busy;
  assign hi_q     = r_hi;
  assign lo_q     = r_lo;
  assign seq_err  = w_sb_err;

endmodule

// File: tb/tb_hilo_unit.sv
// Testbench for hilo_unit: table-driven cycle vectors plus hand-written
// multiply / flush / saturation sequences; MF results are checked against
// a queue filled when a read is expected to be accepted.
module tb_hilo_unit;
  import hilo_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, mul_issue, mul_done;
  logic [31:0] mul_hi, mul_lo, mt_data, mf_data, hi_q, lo_q;
  logic        mt_en, mt_sel, mt_ready, mf_req, mf_sel, mf_ready, mf_valid;
  logic        wb_allin, busy, seq_err;

  always #5 clk = ~clk;

  hilo_unit dut (
    .clk(clk), .reset(reset), .flush(flush),
    .mul_issue(mul_issue), .mul_done(mul_done), .mul_hi(mul_hi), .mul_lo(mul_lo),
    .mt_en(mt_en), .mt_sel(mt_sel), .mt_data(mt_data), .mt_ready(mt_ready),
    .mf_req(mf_req), .mf_sel(mf_sel), .mf_ready(mf_ready),
    .mf_valid(mf_valid), .mf_data(mf_data), .wb_allin(wb_allin),
    .busy(busy), .hi_q(hi_q), .lo_q(lo_q), .seq_err(seq_err)
  );

  typedef struct {
    logic        issue, done;
    logic [31:0] mhi, mlo;
    logic        mt_en, mt_sel;
    logic [31:0] mt_data;
    logic        mf_req, mf_sel, wb, flush;
    logic        exp_rdy, push;
    logic [31:0] exp_mf;
    logic        exp_busy, exp_mfv;
    logic [31:0] exp_hi, exp_lo;
    logic        exp_err;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic        prev_mfv  = 1'b0;
  logic        prev_busy = 1'b0;
  vec_t        tab[12];

  function automatic vec_t mk(
    input logic issue, input logic done, input logic [31:0] mhi, input logic [31:0] mlo,
    input logic mte, input logic mts, input logic [31:0] mtd,
    input logic mfr, input logic mfs, input logic wb, input logic fl,
    input logic rdy, input logic push, input logic [31:0] emf,
    input logic ebusy, input logic emfv, input logic [31:0] ehi, input logic [31:0] elo,
    input logic eerr);
    vec_t v;
    v.issue = issue; v.done = done; v.mhi = mhi; v.mlo = mlo;
    v.mt_en = mte; v.mt_sel = mts; v.mt_data = mtd;
    v.mf_req = mfr; v.mf_sel = mfs; v.wb = wb; v.flush = fl;
    v.exp_rdy = rdy; v.push = push; v.exp_mf = emf;
    v.exp_busy = ebusy; v.exp_mfv = emfv; v.exp_hi = ehi; v.exp_lo = elo;
    v.exp_err = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    flush = 1'b0; mul_issue = 1'b0; mul_done = 1'b0; mul_hi = 32'h0; mul_lo = 32'h0;
    mt_en = 1'b0; mt_sel = 1'b0; mt_data = 32'h0; mf_req = 1'b0; mf_sel = 1'b0;
    wb_allin = 1'b0;
  endtask

  // One clock cycle: drive, check readiness pre-edge, check state post-edge.
  task automatic cyc(input vec_t v);
    @(negedge clk);
    mul_issue = v.issue; mul_done = v.done; mul_hi = v.mhi; mul_lo = v.mlo;
    mt_en = v.mt_en; mt_sel = v.mt_sel; mt_data = v.mt_data;
    mf_req = v.mf_req; mf_sel = v.mf_sel; wb_allin = v.wb; flush = v.flush;
    #1;
    chk("mf_ready", {31'd0, mf_ready}, {31'd0, v.exp_rdy});
    chk("mt_ready", {31'd0, mt_ready}, {31'd0, ~prev_busy});
    if (prev_mfv && (v.wb || v.flush) && exp_q.size() > 0) void'(exp_q.pop_front());
    if (v.push) exp_q.push_back(v.exp_mf);
    @(posedge clk);
    #1;
    chk("busy",     {31'd0, busy},     {31'd0, v.exp_busy});
    chk("mf_valid", {31'd0, mf_valid}, {31'd0, v.exp_mfv});
    chk("hi_q", hi_q, v.exp_hi);
    chk("lo_q", lo_q, v.exp_lo);
    chk("seq_err",  {31'd0, seq_err},  {31'd0, v.exp_err});
    if (v.exp_mfv) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL mf_queue: mf_valid=1 but no result expected (t=%0t)", $time);
      end else begin
        chk("mf_data", mf_data, exp_q[0]);
      end
    end
    prev_mfv  = v.exp_mfv;
    prev_busy = v.exp_busy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    exp_q.delete();
    prev_mfv = 1'b0; prev_busy = 1'b0;
    chk("rst_busy",     {31'd0, busy},     32'd0);
    chk("rst_mt_ready", {31'd0, mt_ready}, 32'd1);
    chk("rst_mf_ready", {31'd0, mf_ready}, 32'd1);
    chk("rst_mf_valid", {31'd0, mf_valid}, 32'd0);
    chk("rst_mf_data",  mf_data, 32'd0);
    chk("rst_hi", hi_q, 32'd0);
    chk("rst_lo", lo_q, 32'd0);
    chk("rst_seq_err",  {31'd0, seq_err},  32'd0);
  endtask

  initial begin
    //          iss dn mhi mlo     mte mts mtd             mfr mfs wb fl  rdy push exp_mf          bsy mfv hi              lo            err
    tab[0]  = mk(0, 0, 0, 0,       0, 0, 32'h0,           1, 1, 0, 0,  1, 1, 32'h0,           0, 1, 32'h0,           32'h0, 0);
    tab[1]  = mk(0, 0, 0, 0,       0, 0, 32'h0,           0, 0, 1, 0,  1, 0, 32'h0,           0, 0, 32'h0,           32'h0, 0);
    tab[2]  = mk(0, 0, 0, 0,       1, 1, 32'hDEAD_BEEF,   0, 0, 0, 0,  1, 0, 32'h0,           0, 0, 32'hDEAD_BEEF,   32'h0, 0);
    tab[3]  = mk(0, 0, 0, 0,       0, 0, 32'h0,           1, 1, 0, 0,  1, 1, 32'hDEAD_BEEF,   0, 1, 32'hDEAD_BEEF,   32'h0, 0);
    tab[4]  = mk(0, 0, 0, 0,       0, 0, 32'h0,           1, 1, 0, 0,  0, 0, 32'h0,           0, 1, 32'hDEAD_BEEF,   32'h0, 0);
    tab[5]  = tab[4];
    tab[6]  = tab[4];
    tab[7]  = mk(0, 0, 0, 0,       0, 0, 32'h0,           0, 0, 1, 0,  1, 0, 32'h0,           0, 0, 32'hDEAD_BEEF,   32'h0, 0);
    tab[8]  = mk(0, 0, 0, 0,       1, 0, 32'h3,           0, 0, 0, 0,  1, 0, 32'h0,           0, 0, 32'hDEAD_BEEF,   32'h3, 0);
    tab[9]  = mk(0, 0, 0, 0,       1, 0, 32'h5,           1, 0, 0, 0,  1, 1, 32'h3,           0, 1, 32'hDEAD_BEEF,   32'h5, 0);
    tab[10] = mk(0, 0, 0, 0,       0, 0, 32'h0,           1, 1, 1, 0,  1, 1, 32'hDEAD_BEEF,   0, 1, 32'hDEAD_BEEF,   32'h5, 0);
    tab[11] = mk(0, 0, 0, 0,       0, 0, 32'h0,           0, 0, 1, 0,  1, 0, 32'h0,           0, 0, 32'hDEAD_BEEF,   32'h5, 0);

    reset = 1'b1;
    idle_inputs();
    do_reset();

    // Reset state, MFHI, MTHI hold/drain, same-cycle MTLO+MFLO, back-to-back.
    for (int i = 0; i < 12; i++) cyc(tab[i]);

    // Multiply flow: MFLO stalls until the cycle after mul_done, then sees new LO.
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 32'hDEAD_BEEF, 32'h5, 0));
    for (int k = 1; k < HILO_MUL_LAT; k++)
      cyc(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF, 32'h5, 0));
    cyc(mk(0, 1, 32'h1, 32'hFFFF_FFFE, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1, 32'hFFFF_FFFE, 0));
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32'hFFFF_FFFE, 0, 1, 32'h1, 32'hFFFF_FFFE, 0));

    // Two issues then flush: pending result, count and issue/MT/MF dropped.
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h1, 32'hFFFF_FFFE, 0));
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h1, 32'hFFFF_FFFE, 0));
    cyc(mk(1, 0, 0, 0, 1, 1, 32'h77, 1, 0, 0, 1, 0, 0, 0, 0, 0, 32'h1, 32'hFFFF_FFFE, 0));
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h1, 32'hFFFF_FFFE, 0));

    // Unmatched mul_done: error, but results written; sticky through flush,
    // and a mul_done during flush is discarded.
    cyc(mk(0, 1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1));
    cyc(mk(0, 1, 32'h99, 32'h99, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1));
    // Issue and done together with one in flight: count stays at 1.
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1));
    cyc(mk(1, 1, 32'h11, 32'h22, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h11, 32'h22, 1));
    cyc(mk(0, 1, 32'h33, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h33, 32'h44, 1));
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 32'h33, 0, 1, 32'h33, 32'h44, 1));
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 32'h33, 32'h44, 1));

    // Saturation: 7 issues fill the counter, the 8th flags an error and
    // is lost, so exactly 7 completions drain it.
    do_reset();
    for (int k = 0; k < 7; k++)
      cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, (k == 0), 0, 0, 1, 0, 32'h0, 32'h0, 0));
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 1));
    for (int k = 0; k < 6; k++)
      cyc(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 1));
    cyc(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Architectural HI/LO register block at the consumer end of the MUL functional unit. It tracks multiplies in flight, captures `mul_hi`/`mul_lo` on the MUL completion strobe, and accepts MTHI/MTLO writes. It serves MFHI/MFLO reads through a one-entry output register with a valid/allin handshake toward writeback. It sits beside the MUL unit in the EX stage, between issue, MUL and WB_transfer.

## Interface
Parameters:
- `DATA_W`, 32, width of HI, LO and all data ports.
- `CNT_W`, 3, width of the in-flight multiply counter; maximum count is 2^CNT_W−1.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  pipeline flush; synchronous and same priority as reset for speculative state only.
- `mul_issue`  in  1  a MULT/MULTU enters MUL this cycle.
- `mul_done`  in  1  MUL completion strobe (MUL `CE_out`).
- `mul_hi`  in  DATA_W  MUL high result; valid when `mul_done`=1.
- `mul_lo`  in  DATA_W  MUL low result; valid when `mul_done`=1.
- `mt_en`  in  1  MTHI/MTLO request.
- `mt_sel`  in  1  0=LO, 1=HI.
- `mt_data`  in  DATA_W  move-to data.
- `mt_ready`  out  1  MT request is accepted this cycle.
- `mf_req`  in  1  MFHI/MFLO request.
- `mf_sel`  in  1  0=LO, 1=HI.
- `mf_ready`  out  1  MF request is accepted this cycle.
- `mf_valid`  out  1  output register holds a result.
- `mf_data`  out  DATA_W  MF result.
- `wb_allin`  in  1  WB accepts `mf_data` this cycle.
- `busy`  out  1  one or more multiplies are in flight.
- `hi_q`  out  DATA_W  current HI value.
- `lo_q`  out  DATA_W  current LO value.
- `seq_err`  out  1  sticky protocol error flag.

## Operation
- In-flight counter `cnt`:
  - +1 on `mul_issue` alone; −1 on `mul_done` alone; unchanged when both are high.
  - `busy` = (`cnt` ≠ 0).
- Error cases, each of which sets `seq_err` (cleared only by `reset`):
  - `mul_done` with `cnt`=0: counter is held at 0. HI/LO are still written, because results are never dropped.
  - `mul_issue` alone with `cnt` = max: counter saturates.
- `mul_done`=1 writes `hi_q`←`mul_hi` and `lo_q`←`mul_lo` in the same edge.
- MT path:
  - `mt_ready` = ~`busy`.
  - An accepted MT writes the register selected by `mt_sel`.
  - `mul_done` and an accepted MT in the same cycle cannot both occur, because `busy` was 1 that cycle.
- MF path:
  - `mf_ready` = ~`busy` & (~`mf_valid` | `wb_allin`).
  - On accept, `mf_data` is loaded with the pre-edge value of the selected register and `mf_valid` is set.
  - `mf_valid` clears on `wb_allin` with no new accept.
  - `mf_data` holds steady while `mf_valid`=1 and `wb_allin`=0.
- MT and MF accepted in the same cycle to the same register: MF returns the old value and MT lands on the same edge.
- `flush`=1:
  - `cnt`←0 and `mf_valid`←0.
  - `mul_issue`, MT and MF requests that cycle are ignored.
  - `hi_q`, `lo_q` and `seq_err` are kept, because committed state survives a flush.
  - A `mul_done` coinciding with `flush` is discarded, since MUL also flushes.
- Reset values: `hi_q`=0, `lo_q`=0, `cnt`=0, `mf_valid`=0, `mf_data`=0, `seq_err`=0.
  - Resulting outputs: `busy`=0, `mt_ready`=1, `mf_ready`=1.

## Timing
- MF latency: a request accepted at edge N gives `mf_valid`=1 and `mf_data` from N+1. Back-to-back MF reads sustain one per cycle while `wb_allin`=1.
- `busy` rises the cycle after `mul_issue` and falls the cycle after the last `mul_done`.
- An MF stalled on `busy` is accepted at the first edge where `cnt`=0. The earliest such edge is the one after `mul_done`, and that read sees the new HI/LO. There is no same-cycle forwarding from `mul_hi`/`mul_lo`.
- `mt_ready` and `mf_ready` are combinational from state and `wb_allin` only. They do not depend on `mt_en` or `mf_req`.

## Structure
- Shared package holds:
  - `HILO_SEL_LO`=1'b0 and `HILO_SEL_HI`=1'b1.
  - `DATA_W` default.
  - The MUL latency constant, 6, which the bench uses.
- Optional sub-module `hilo_scoreboard`: the saturating up/down `cnt`, with `busy` and the overflow/underflow part of `seq_err`. The rest stays flat.

## Test plan
- Reset then MFHI: `mf_req`=1, `mf_sel`=1 → `mf_valid`=1 next cycle with `mf_data`=0; `busy`=0.
- Multiply flow:
  - `mul_issue` at cycle 0, then `mf_req` for LO held from cycle 1 → `mf_ready`=0 through cycle 6.
  - `mul_done` at cycle 6 with `mul_hi`=32'h0000_0001 and `mul_lo`=32'hFFFF_FFFE.
  - MF accepted at the cycle-7 edge → `mf_data`=32'hFFFF_FFFE.
- MTHI 32'hDEAD_BEEF, then MFHI with `wb_allin`=0 for 3 cycles → `mf_data` holds 32'hDEAD_BEEF and `mf_ready`=0; it drains on the first `wb_allin`=1.
- Two `mul_issue` pulses, then `flush` before any `mul_done` → `cnt`=0, `busy`=0, `mf_valid`=0, and HI/LO are unchanged from their prior values.
- Error and boundary cases:
  - `mul_done` with `cnt`=0 → `seq_err`=1 (sticky through `flush`), and HI/LO are updated.
  - `mul_issue` and `mul_done` in the same cycle with `cnt`=1 → `cnt` stays 1.
- Same-cycle MTLO 32'h5 and MFLO, with LO previously 32'h3 → `mf_data`=32'h3, and `lo_q`=32'h5 after the edge.
